// File: rtl/quat_norm_pkg.sv
// Shared FSM state encoding and component-index sizing for quat_normalizer.
package quat_norm_pkg;

  localparam int NUM_COMP = 4;
  localparam int IDX_W    = $clog2(NUM_COMP);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_COMP - 1);

  typedef enum logic [2:0] {
    IDLE,
    SQUARE,
    REQ,
    WAIT_RESP,
    SCALE,
    DONE
  } state_t;

endpackage

// File: rtl/fix_mul_sat.sv
// Combinational signed fixed-point multiply, shift by FRACT_WIDTH and saturate to W bits.
// Build option QUAT_NORM_ROUND_EN: round half up before the shift instead of truncating.
module fix_mul_sat #(
  parameter int INT_WIDTH   = 12,
  parameter int FRACT_WIDTH = 4
) (
  input  logic signed [INT_WIDTH+FRACT_WIDTH-1:0] a,
  input  logic signed [INT_WIDTH+FRACT_WIDTH:0]   b,
  output logic signed [INT_WIDTH+FRACT_WIDTH-1:0] y
);

  localparam int W  = INT_WIDTH + FRACT_WIDTH;
  localparam int PW = 2 * W + 1;

  localparam logic signed [PW-1:0] MAX_EXT = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_EXT = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};
`ifdef QUAT_NORM_ROUND_EN
  localparam logic signed [PW-1:0] HALF = PW'(1) <<< (FRACT_WIDTH - 1);
`endif

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;

  function automatic logic signed [PW-1:0] scale_down(input logic signed [PW-1:0] p);
`ifdef QUAT_NORM_ROUND_EN
    return (p + HALF) >>> FRACT_WIDTH;
`else
    return p >>> FRACT_WIDTH;
`endif
  endfunction

  function automatic logic signed [W-1:0] sat_s(input logic signed [PW-1:0] v);
    logic signed [W-1:0] r;
    if (v > MAX_EXT) begin
      r = MAX_EXT[W-1:0];
    end else if (v < MIN_EXT) begin
      r = MIN_EXT[W-1:0];
    end else begin
      r = v[W-1:0];
    end
    return r;
  endfunction

  // b is one bit wider so an unsigned W-bit operand can be zero-extended into it
  assign a_ext = {{(PW-W){a[W-1]}}, a};
  assign b_ext = {{(PW-W-1){b[W]}}, b};
  assign prod  = a_ext * b_ext;
  assign y     = sat_s(scale_down(prod));

endmodule

// File: rtl/quat_normalizer.sv
// Normalises a fixed-point quaternion using an external inverse-square-root responder.
// One shared fix_mul_sat computes squares and scaled outputs; QUAT_NORM_ROUND_EN selects rounding.
module quat_normalizer
  import quat_norm_pkg::*;
#(
  parameter int INT_WIDTH   = 12,
  parameter int FRACT_WIDTH = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic signed [INT_WIDTH+FRACT_WIDTH-1:0] in_q0,
  input  logic signed [INT_WIDTH+FRACT_WIDTH-1:0] in_q1,
  input  logic signed [INT_WIDTH+FRACT_WIDTH-1:0] in_q2,
  input  logic signed [INT_WIDTH+FRACT_WIDTH-1:0] in_q3,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  output logic        [INT_WIDTH+FRACT_WIDTH-1:0] req_data,
  output logic                                    req_valid,
  input  logic                                    req_ready,
  input  logic        [INT_WIDTH+FRACT_WIDTH-1:0] resp_data,
  input  logic                                    resp_valid,
  output logic                                    resp_ready,
  output logic signed [INT_WIDTH+FRACT_WIDTH-1:0] out_q0,
  output logic signed [INT_WIDTH+FRACT_WIDTH-1:0] out_q1,
  output logic signed [INT_WIDTH+FRACT_WIDTH-1:0] out_q2,
  output logic signed [INT_WIDTH+FRACT_WIDTH-1:0] out_q3,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    out_zero
);

  localparam int W = INT_WIDTH + FRACT_WIDTH;
  localparam logic [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic signed [W-1:0] q_reg [NUM_COMP];
  logic signed [W-1:0] res   [NUM_COMP];
  logic [W-1:0]        acc;
  logic [W-1:0]        acc_next;
  logic [W-1:0]        inv;
  logic signed [W-1:0] mul_a;
  logic signed [W:0]   mul_b;
  logic signed [W-1:0] mul_y;
  logic                take_in;
  logic                take_resp;

  // Accumulator stays inside positive signed range so the responder sees a valid operand
  function automatic logic [W-1:0] sat_u(input logic [W-1:0] sum_in,
                                         input logic signed [W-1:0] term);
    logic [W:0] total;
    total = {1'b0, sum_in} + {1'b0, term};
    return (total > {1'b0, ACC_MAX}) ? ACC_MAX : total[W-1:0];
  endfunction

  assign take_in   = (state == IDLE) && in_valid && in_ready;
  assign take_resp = (state == WAIT_RESP) && resp_valid && resp_ready;

  always_comb begin
    mul_a = q_reg[idx];
    if (state == SCALE) begin
      mul_b = {1'b0, inv};
    end else begin
      mul_b = {q_reg[idx][W-1], q_reg[idx]};
    end
  end

  fix_mul_sat #(
    .INT_WIDTH   (INT_WIDTH),
    .FRACT_WIDTH (FRACT_WIDTH)
  ) u_mul (
    .a (mul_a),
    .b (mul_b),
    .y (mul_y)
  );

  assign acc_next = sat_u(acc, mul_y);

  // Datapath registers: loaded under FSM qualifiers, no reset needed
  always_ff @(posedge clk) begin
    if (take_in) begin
      q_reg[0] <= in_q0;
      q_reg[1] <= in_q1;
      q_reg[2] <= in_q2;
      q_reg[3] <= in_q3;
      acc      <= '0;
    end else if (state == SQUARE) begin
      acc <= acc_next;
    end
    if (take_resp) begin
      inv <= resp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      in_ready   <= 1'b0;
      req_valid  <= 1'b0;
      req_data   <= '0;
      resp_ready <= 1'b0;
      out_valid  <= 1'b0;
      out_zero   <= 1'b0;
      for (int i = 0; i < NUM_COMP; i++) res[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (take_in) begin
            in_ready <= 1'b0;
            idx      <= '0;
            state    <= SQUARE;
          end
        end
        SQUARE: begin
          idx <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            if (acc_next == '0) begin
              for (int i = 0; i < NUM_COMP; i++) res[i] <= '0;
              out_zero  <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              req_data  <= acc_next;
              req_valid <= 1'b1;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (req_valid && req_ready) begin
            req_valid  <= 1'b0;
            resp_ready <= 1'b1;
            state      <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (take_resp) begin
            resp_ready <= 1'b0;
            idx        <= '0;
            state      <= SCALE;
          end
        end
        SCALE: begin
          res[idx] <= mul_y;
          idx      <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            out_valid <= 1'b1;
            out_zero  <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_q0 = res[0];
  assign out_q1 = res[1];
  assign out_q2 = res[2];
  assign out_q3 = res[3];

endmodule

// File: tb/tb_quat_normalizer.sv
// Directed, table-driven bench for quat_normalizer (Q12.4) with a cycle-level responder model.
// Expectations for the rounding vectors follow QUAT_NORM_ROUND_EN when it is defined.
module tb_quat_normalizer;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_q0, in_q1, in_q2, in_q3;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] req_data;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] resp_data;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] out_q0, out_q1, out_q2, out_q3;
  logic         out_valid;
  logic         out_ready;
  logic         out_zero;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] q0, q1, q2, q3;
    logic [W-1:0] resp;
    int           req_stall;
    int           resp_delay;
    int           out_stall;
    int           hold_in;
    int           exp_zero;
    logic [W-1:0] exp_req;
    logic [W-1:0] e0, e1, e2, e3;
    int           exp_lat;
  } vec_t;

  vec_t vecs [11];

  quat_normalizer #(
    .INT_WIDTH   (12),
    .FRACT_WIDTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_q0      (in_q0),
    .in_q1      (in_q1),
    .in_q2      (in_q2),
    .in_q3      (in_q3),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .out_q0     (out_q0),
    .out_q1     (out_q1),
    .out_q2     (out_q2),
    .out_q3     (out_q3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_zero   (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"},   in_ready,   0);
    check({tag, " req_valid"},  req_valid,  0);
    check({tag, " req_data"},   req_data,   0);
    check({tag, " resp_ready"}, resp_ready, 0);
    check({tag, " out_valid"},  out_valid,  0);
    check({tag, " out_zero"},   out_zero,   0);
    check({tag, " out_q0"},     out_q0,     0);
    check({tag, " out_q1"},     out_q1,     0);
    check({tag, " out_q2"},     out_q2,     0);
    check({tag, " out_q3"},     out_q3,     0);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int cyc, stall_cnt, ostall, resp_wait;
    bit seen_req, seen_out, resp_drop, released, done;
    cyc = 1; stall_cnt = 0; ostall = 0; resp_wait = -1;
    seen_req = 0; seen_out = 0; resp_drop = 0; released = 0; done = 0;
    req_ready  = (v.req_stall == 0);
    out_ready  = 1'b0;
    resp_valid = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d in_ready_idle", id), in_ready, 1);
    in_q0 = v.q0; in_q1 = v.q1; in_q2 = v.q2; in_q3 = v.q3;
    in_valid = 1'b1;
    @(posedge clk);
    while (!done && cyc <= 60) begin
      @(negedge clk);
      if (released) begin
        check($sformatf("v%0d out_valid_drop", id), out_valid, 0);
        check($sformatf("v%0d in_ready_back", id), in_ready, 1);
        done = 1;
      end else begin
        if (v.hold_in == 0) begin
          in_valid = 1'b0;
        end else begin
          in_q0 = 16'h7777; in_q1 = 16'h1234; in_q2 = 16'h4321; in_q3 = 16'h0F0F;
        end
        if (resp_drop) begin
          resp_valid = 1'b0;
          resp_drop  = 0;
        end
        if (resp_wait == 0) begin
          resp_valid = 1'b1;
          resp_data  = v.resp;
          resp_wait  = -1;
        end else if (resp_wait > 0) begin
          resp_wait--;
        end
        if (req_valid) begin
          seen_req = 1;
          check($sformatf("v%0d req_data c%0d", id, cyc), req_data, v.exp_req);
          if (stall_cnt < v.req_stall) begin
            req_ready = 1'b0;
            stall_cnt++;
          end else begin
            req_ready = 1'b1;
            if (v.resp_delay < 0) begin
              resp_valid = 1'b1;
              resp_data  = v.resp;
            end else begin
              resp_wait = v.resp_delay;
            end
          end
        end
        if (resp_valid && resp_ready) resp_drop = 1;
        if (out_valid) begin
          if (!seen_out) begin
            seen_out = 1;
            in_valid = 1'b0;
            check($sformatf("v%0d latency", id), cyc, v.exp_lat);
            check($sformatf("v%0d out_zero", id), out_zero, v.exp_zero);
            check($sformatf("v%0d req_issued", id), seen_req, (v.exp_zero == 0));
          end
          check($sformatf("v%0d out_q0 c%0d", id, cyc), out_q0, v.e0);
          check($sformatf("v%0d out_q1 c%0d", id, cyc), out_q1, v.e1);
          check($sformatf("v%0d out_q2 c%0d", id, cyc), out_q2, v.e2);
          check($sformatf("v%0d out_q3 c%0d", id, cyc), out_q3, v.e3);
          check($sformatf("v%0d in_ready_busy c%0d", id, cyc), in_ready, 0);
          if (ostall < v.out_stall) begin
            out_ready = 1'b0;
            ostall++;
          end else begin
            out_ready = 1'b1;
            released  = 1;
          end
        end
        cyc++;
      end
    end
    check($sformatf("v%0d completed", id), done, 1);
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    req_ready  = 1'b1;
    resp_valid = 1'b0;
  endtask

  int wait_cnt;

  initial begin
    // q0..q3, resp, req_stall, resp_delay, out_stall, hold_in, exp_zero, exp_req, e0..e3, exp_lat
    vecs[0]  = '{16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 0, 0, 0, 0, 0, 16'h0010,
                 16'h0010, 16'h0000, 16'h0000, 16'h0000, 11};
    vecs[1]  = '{16'h0020, 16'h0000, 16'h0000, 16'h0000, 16'h0008, 0, 0, 0, 0, 0, 16'h0040,
                 16'h0010, 16'h0000, 16'h0000, 16'h0000, 11};
    vecs[2]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 0, 0, 0, 0, 1, 16'h0000,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5};
    vecs[3]  = '{16'h7FF0, 16'h7FF0, 16'h7FF0, 16'h7FF0, 16'h0010, 0, -1, 0, 0, 0, 16'h7FFF,
                 16'h7FF0, 16'h7FF0, 16'h7FF0, 16'h7FF0, 11};
    vecs[4]  = '{16'hFFF0, 16'h0010, 16'hFFF0, 16'h0010, 16'h0008, 0, 0, 0, 0, 0, 16'h0040,
                 16'hFFF8, 16'h0008, 16'hFFF8, 16'h0008, 11};
    vecs[6]  = '{16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0008, 3, 2, 5, 1, 0, 16'h0040,
                 16'h0008, 16'h0008, 16'h0008, 16'h0008, 16};
    vecs[7]  = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 0, 0, 0, 16'h1000,
                 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 11};
    vecs[9]  = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 0, 0, 0, 0, 0, 16'h7FFF,
                 16'h8000, 16'h0000, 16'h0000, 16'h0000, 11};
    vecs[10] = '{16'h0030, 16'h0040, 16'h0000, 16'h0000, 16'h0003, 0, 0, 0, 0, 0, 16'h0190,
                 16'h0009, 16'h000C, 16'h0000, 16'h0000, 11};
`ifdef QUAT_NORM_ROUND_EN
    vecs[5]  = '{16'hFFEF, 16'h0000, 16'h0000, 16'h0000, 16'h0008, 0, 0, 0, 0, 0, 16'h0012,
                 16'hFFF8, 16'h0000, 16'h0000, 16'h0000, 11};
    vecs[8]  = '{16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 0, 0, 0, 0, 0, 16'h0001,
                 16'h000C, 16'h0000, 16'h0000, 16'h0000, 11};
`else
    vecs[5]  = '{16'hFFEF, 16'h0000, 16'h0000, 16'h0000, 16'h0008, 0, 0, 0, 0, 0, 16'h0012,
                 16'hFFF7, 16'h0000, 16'h0000, 16'h0000, 11};
    vecs[8]  = '{16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 0, 0, 0, 0, 1, 16'h0000,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5};
`endif

    rst_n = 1'b0;
    in_valid = 1'b0; in_q0 = '0; in_q1 = '0; in_q2 = '0; in_q3 = '0;
    req_ready = 1'b1; resp_valid = 1'b0; resp_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Reset while waiting for the response, then a fresh transaction
    @(negedge clk);
    in_q0 = 16'h0010; in_q1 = '0; in_q2 = '0; in_q3 = '0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!resp_ready && wait_cnt < 30) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("rst reached WAIT_RESP", resp_ready, 1);
    check("rst req_data before", req_data, 16'h0010);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("held_rst");
    rst_n = 1'b1;
    run_vec(100, vecs[1]);
    run_vec(101, vecs[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
